// File: rtl/array_walker.sv
// +----------------------------------------------------------------------------+
// | array_walker: SUM/FILL walker over a word array with valid/ready handshake  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module array_walker #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_op,
  input  logic [ADDR_W-1:0] i_in_base,
  input  logic [ADDR_W:0]   i_in_len,
  input  logic [DATA_W-1:0] i_in_value,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_di,
  input  logic [DATA_W-1:0] i_mem_do,
  output logic              o_mem_valid,
  input  logic              i_mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_max_len = (ADDR_W+1)'(MAX_LEN);

  state_t              r_state;
  logic                r_op;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_value;
  logic [ADDR_W:0]     r_idx;
  logic [DATA_W-1:0]   r_acc;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_di;
  logic                r_mem_valid;

  logic [ADDR_W:0]     w_len_clamped;
  logic [ADDR_W:0]     w_idx_inc;
  logic [DATA_W-1:0]   w_acc_sum;

  assign w_len_clamped = (i_in_len > c_max_len) ? c_max_len : i_in_len;
  assign w_idx_inc     = r_idx + (ADDR_W+1)'(1);
  assign w_acc_sum     = r_acc + i_mem_do;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_value     <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_di    <= '0;
      r_mem_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_op       <= i_in_op;
            r_base     <= i_in_base;
            r_len      <= w_len_clamped;
            r_value    <= i_in_value;
            r_idx      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            if (w_len_clamped == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
            end else begin
              r_state     <= S_ISSUE;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= i_in_base;
              r_mem_we    <= i_in_op;
              r_mem_di    <= i_in_value;
            end
          end
        end
        S_ISSUE: begin
          if (i_mem_ready) begin
            if (r_op) begin
              r_idx <= w_idx_inc;
              if (w_idx_inc == r_len) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_out_data  <= DATA_W'(r_len);
                r_mem_valid <= 1'b0;
                r_mem_we    <= 1'b0;
              end else begin
                r_mem_addr <= r_base + w_idx_inc[ADDR_W-1:0];
                r_mem_di   <= r_value + DATA_W'(w_idx_inc);
              end
            end else begin
              // Read data arrives one cycle later; address stays put for it.
              r_mem_valid <= 1'b0;
              r_state     <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          r_acc <= w_acc_sum;
          r_idx <= w_idx_inc;
          if (w_idx_inc == r_len) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_sum;
          end else begin
            r_state     <= S_ISSUE;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= r_base + w_idx_inc[ADDR_W-1:0];
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_di    = r_mem_di;
  assign o_mem_valid = r_mem_valid;

endmodule

`default_nettype wire

// File: tb/tb_array_walker.sv
// +----------------------------------------------------------------------------+
// | tb_array_walker: directed bench with a 16-word registered-read array model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_array_walker;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [3:0]  in_base;
  logic [4:0]  in_len;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic        mem_valid;
  logic        mem_ready;

  logic [31:0] mem [16];
  logic [3:0]  log_addr [$];
  bit          we_seen;
  bit          valid_seen;
  bit          tog;
  int          n_pass;
  int          n_total;

  always #5 clk = ~clk;

  array_walker #(.ADDR_W(4), .DATA_W(32), .MAX_LEN(16)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_op     (in_op),
    .i_in_base   (in_base),
    .i_in_len    (in_len),
    .i_in_value  (in_value),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_di    (mem_di),
    .i_mem_do    (mem_do),
    .o_mem_valid (mem_valid),
    .i_mem_ready (mem_ready)
  );

  // Array responder: registered read of the current address, optional toggling ready.
  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      log_addr.push_back(mem_addr);
      if (mem_we) mem[mem_addr] <= mem_di;
    end
    if (mem_valid) valid_seen = 1'b1;
    if (mem_valid && mem_we) we_seen = 1'b1;
    mem_do    <= mem[mem_addr];
    mem_ready <= tog ? ~mem_ready : 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_cmd(input logic op, input logic [3:0] base, input logic [4:0] len,
                         input logic [31:0] value, output logic [31:0] res, output int lat);
    int guard = 0;
    in_valid = 1'b1; in_op = op; in_base = base; in_len = len; in_value = value;
    while (!in_ready && guard < 100) begin step(); guard++; end
    step();
    in_valid = 1'b0; in_base = ~base; in_value = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    res = out_valid ? out_data : 'x;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    step(); step();
    check32("reset in_ready", {31'd0, in_ready}, 32'd1);
    check32("reset out_valid", {31'd0, out_valid}, 32'd0);
    check32("reset out_data", out_data, 32'd0);
    check32("reset mem_valid/we/addr", {26'd0, mem_valid, mem_we, mem_addr}, 32'd0);
    check32("reset mem_di", mem_di, 32'd0);
    nrst = 1'b1;
    step();
  endtask

  task automatic test_sum_toggle();
    logic [31:0] res; int lat; bit order_ok;
    tog = 1'b1; log_addr.delete(); we_seen = 1'b0;
    run_cmd(1'b0, 4'd0, 5'd16, 32'd0, res, lat);
    check32("sum16 toggle result", res, 32'd120);
    check32("sum16 transfer count", log_addr.size(), 32'd16);
    order_ok = (log_addr.size() == 16);
    for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] != 4'(i)) order_ok = 1'b0;
    check32("sum16 address order", {31'd0, order_ok}, 32'd1);
    check32("sum16 no writes", {31'd0, we_seen}, 32'd0);
    tog = 1'b0;
  endtask

  task automatic test_sum_wrap();
    logic [31:0] res; int lat;
    log_addr.delete();
    run_cmd(1'b0, 4'd14, 5'd4, 32'd0, res, lat);
    check32("sum wrap result", res, 32'd30);
    check32("sum wrap addresses",
            (log_addr.size() == 4) ? {16'd0, log_addr[0], log_addr[1], log_addr[2], log_addr[3]} : 32'hFFFF_FFFF,
            32'h0000_EF01);
    check32("sum4 latency", lat, 32'd8);
  endtask

  task automatic test_fill();
    logic [31:0] res; int lat;
    log_addr.delete();
    run_cmd(1'b1, 4'd4, 5'd3, 32'd100, res, lat);
    check32("fill result", res, 32'd3);
    check32("fill latency", lat, 32'd3);
    check32("fill addresses",
            (log_addr.size() == 3) ? {20'd0, log_addr[0], log_addr[1], log_addr[2]} : 32'hFFFF_FFFF,
            32'h0000_0456);
    check32("fill mem[4]", mem[4], 32'd100);
    check32("fill mem[6]", mem[6], 32'd102);
    run_cmd(1'b0, 4'd4, 5'd3, 32'd0, res, lat);
    check32("sum after fill", res, 32'd303);
  endtask

  task automatic test_len_edges();
    logic [31:0] res; int lat;
    valid_seen = 1'b0;
    run_cmd(1'b0, 4'd3, 5'd0, 32'd0, res, lat);
    check32("len0 result", res, 32'd0);
    check32("len0 latency", lat, 32'd0);
    check32("len0 no mem access", {31'd0, valid_seen}, 32'd0);
    log_addr.delete();
    run_cmd(1'b0, 4'd0, 5'd20, 32'd0, res, lat);
    check32("len20 clamped sum", res, 32'd408);
    check32("len20 clamped count", log_addr.size(), 32'd16);
  endtask

  task automatic test_backpressure();
    logic [31:0] held; int guard = 0; bit stable_ok = 1'b1;
    in_valid = 1'b1; in_op = 1'b0; in_base = 4'd0; in_len = 5'd2; in_value = 32'd0;
    while (!in_ready && guard < 100) begin step(); guard++; end
    step();
    in_base = 4'd2; in_len = 5'd1;
    guard = 0;
    while (!out_valid && guard < 100) begin step(); guard++; end
    held = out_data;
    check32("bp first result", held, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (!out_valid || out_data !== held || in_ready) stable_ok = 1'b0;
    end
    check32("bp outputs held, in_ready low", {31'd0, stable_ok}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check32("bp after handshake", {30'd0, out_valid, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check32("bp second accepted", {31'd0, in_ready}, 32'd0);
    guard = 0;
    while (!out_valid && guard < 100) begin step(); guard++; end
    check32("bp second result", out_valid ? out_data : 'x, 32'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [31:0] res; int lat; int guard = 0; int n_log;
    log_addr.delete();
    in_valid = 1'b1; in_op = 1'b0; in_base = 4'd0; in_len = 5'd8; in_value = 32'd0;
    while (!in_ready && guard < 100) begin step(); guard++; end
    step();
    in_valid = 1'b0;
    guard = 0;
    while (log_addr.size() < 3 && guard < 100) begin step(); guard++; end
    nrst = 1'b0;
    step();
    check32("midrst outputs",
            {27'd0, in_ready, out_valid, mem_valid, mem_we, |mem_addr}, 32'h10);
    check32("midrst out_data/mem_di", out_data | mem_di, 32'd0);
    nrst = 1'b1;
    n_log = log_addr.size();
    step(); step(); step();
    check32("midrst no traffic", log_addr.size() - n_log, 32'd0);
    run_cmd(1'b0, 4'd0, 5'd4, 32'd0, res, lat);
    check32("midrst follow-up sum", res, 32'd6);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    tog = 1'b0; mem_ready = 1'b1; mem_do = '0;
    we_seen = 1'b0; valid_seen = 1'b0;
    nrst = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_base = '0; in_len = '0;
    in_value = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);
    test_reset();
    test_sum_toggle();
    test_sum_wrap();
    test_fill();
    test_len_edges();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
